// File: rtl/hififo_tx_wr_arb.sv
// Round-robin write-request arbiter: merges four TPC FIFO write streams into
// the single pcie_tx write-request input. Whole TLPs are granted (grant held
// until the last beat), the output beat is registered, and per-port completed
// TLP counters plus a sticky framing error flag are kept for status readback.
module hififo_tx_wr_arb #(
  parameter int         NPORTS    = 4,
  parameter int         MAX_BEATS = 17,
  parameter logic [7:0] ENABLE    = 8'h10
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NPORTS-1:0]      in_valid,
  output logic [NPORTS-1:0]      in_ready,
  input  logic [65:0]            in_data0,
  input  logic [65:0]            in_data1,
  input  logic [65:0]            in_data2,
  input  logic [65:0]            in_data3,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [65:0]            out_data,
  output logic [1:0]             out_port,
  output logic                   err,
  output logic [16*NPORTS-1:0]   pkt_count
);

  // Bits [7:4] of ENABLE gate ports 0..3.
  localparam logic [NPORTS-1:0] EN_MASK   = ENABLE[4 +: NPORTS];
  // Wide enough to count past MAX_BEATS so an over-long TLP is still visible.
  localparam int                CNT_W     = $clog2(MAX_BEATS + 2);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_BEATS - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = '1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_gnt;
  logic [1:0]       r_ptr;
  logic             r_out_valid;
  logic [65:0]      r_out_data;
  logic [1:0]       r_out_port;
  logic             r_err;
  logic [CNT_W-1:0] r_beat_cnt;
  logic [15:0]      r_pkt_cnt [NPORTS];

  logic [65:0]      w_port_data [4];
  logic [65:0]      w_sel_data;
  logic [NPORTS-1:0] w_en_valid;
  logic [NPORTS-1:0] w_in_ready;
  logic             w_can_take;
  logic             w_accept;
  logic             w_first;
  logic             w_last;
  logic             w_found;
  logic [1:0]       w_pick;
  logic [1:0]       w_idx;

  assign w_port_data[0] = in_data0;
  assign w_port_data[1] = in_data1;
  assign w_port_data[2] = in_data2;
  assign w_port_data[3] = in_data3;

  assign w_sel_data = w_port_data[r_gnt];
  assign w_first    = w_sel_data[64];
  assign w_last     = w_sel_data[65];
  assign w_en_valid = in_valid & EN_MASK;

  // The granted port may push a beat whenever the output register is empty
  // or being drained this cycle; this keeps one beat per cycle at full rate.
  assign w_can_take = (r_state == S_GRANT) && EN_MASK[r_gnt] && (!r_out_valid || out_ready);
  assign w_accept   = w_can_take && in_valid[r_gnt];

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state, round-robin pick and per-port ready.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_in_ready  = '0;
    w_found     = 1'b0;
    w_pick      = '0;
    w_idx       = '0;
    case (r_state)
      S_IDLE: begin
        // First enabled valid port at or after the pointer, wrapping 3 -> 0.
        for (int i = 0; i < NPORTS; i++) begin
          w_idx = r_ptr + 2'(i);
          if (!w_found && w_en_valid[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
          end
        end
        if (w_found) w_state_nxt = S_GRANT;
      end
      S_GRANT: begin
        w_in_ready[r_gnt] = w_can_take;
        if (w_accept && w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready = w_in_ready;

  // Grant and round-robin pointer: grant latched in IDLE, pointer moves past
  // the granted port when its TLP completes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_gnt <= '0;
      r_ptr <= '0;
    end else begin
      if (r_state == S_IDLE && w_found) r_gnt <= w_pick;
      if (w_accept && w_last)           r_ptr <= r_gnt + 2'd1;
    end
  end

  // Output register: load on accept, drain on out_ready, otherwise hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_port  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_port  <= r_gnt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Beat counter within the current TLP and sticky framing error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      if (w_last)                     r_beat_cnt <= '0;
      else if (r_beat_cnt != CNT_SAT) r_beat_cnt <= r_beat_cnt + 1'b1;
      // Missing header flag, or the count reaches MAX_BEATS without a last beat.
      if ((r_beat_cnt == '0 && !w_first) || (r_beat_cnt == CNT_LIMIT && !w_last))
        r_err <= 1'b1;
    end
  end

  // Completed-TLP counters, one per port, wrapping at 16 bits.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: this small counter array is reset like ordinary flops; status
    // readback must show zero right after reset, so it is not left as RAM.
    if (!reset_n) begin
      for (int p = 0; p < NPORTS; p++) r_pkt_cnt[p] <= '0;
    end else if (w_accept && w_last) begin
      r_pkt_cnt[r_gnt] <= r_pkt_cnt[r_gnt] + 16'd1;
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_pkt
    assign pkt_count[16*p +: 16] = r_pkt_cnt[p];
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_port  = r_out_port;
  assign err       = r_err;

endmodule

// File: tb/tb_hififo_tx_wr_arb.sv
// Bench for hififo_tx_wr_arb: a cycle table for the two-port handoff, then
// directed multi-cycle sequences driven by a small source/sink scoreboard.
module tb_hififo_tx_wr_arb;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  in_valid;
  logic [65:0] in_data [4];
  logic        out_ready;

  logic [3:0]  in_ready,  in_ready5;
  logic        out_valid, out_valid5;
  logic [65:0] out_data,  out_data5;
  logic [1:0]  out_port,  out_port5;
  logic        err,       err5;
  logic [63:0] pkt_count, pkt_count5;

  always #5 clock = ~clock;

  hififo_tx_wr_arb #(.ENABLE(8'hF0)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data0(in_data[0]), .in_data1(in_data[1]), .in_data2(in_data[2]), .in_data3(in_data[3]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_port(out_port),
    .err(err), .pkt_count(pkt_count)
  );

  hififo_tx_wr_arb #(.ENABLE(8'h30)) dut5 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready5),
    .in_data0(in_data[0]), .in_data1(in_data[1]), .in_data2(in_data[2]), .in_data3(in_data[3]),
    .out_valid(out_valid5), .out_ready(out_ready), .out_data(out_data5), .out_port(out_port5),
    .err(err5), .pkt_count(pkt_count5)
  );

  // The scoreboard follows either the all-enabled instance or the 8'h30 one.
  logic        sel5;
  logic [3:0]  s_rdy;
  logic        s_ov, s_err;
  logic [65:0] s_od;
  logic [1:0]  s_port;
  logic [63:0] s_pkt;
  always_comb begin
    s_rdy  = sel5 ? in_ready5  : in_ready;
    s_ov   = sel5 ? out_valid5 : out_valid;
    s_od   = sel5 ? out_data5  : out_data;
    s_port = sel5 ? out_port5  : out_port;
    s_err  = sel5 ? err5       : err;
    s_pkt  = sel5 ? pkt_count5 : pkt_count;
  end

  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [65:0] mk(input int p, input int t, input int b, input bit first, input bit last);
    return {last, first, 8'hA0, p[7:0], t[15:0], b[15:0], 16'h5A5A};
  endfunction

  // ---------------- scoreboard state ----------------
  int tlps_left [4];
  int nbeats    [4];
  bit bad_first [4];
  int src_tlp   [4];
  int src_beat  [4];
  int snk_tlp   [4];
  int snk_beat  [4];
  int rx_cnt    [4];
  int exp_total, rx_total, cyc, last_acc;
  bit toggle_rdy, long_chk, gap_chk;
  int gnt_q [$];

  function automatic logic [65:0] beat_of(input int p, input int t, input int b);
    return mk(p, t, b, (b == 0) && !bad_first[p], b == nbeats[p] - 1);
  endfunction

  task automatic clear_plan();
    for (int p = 0; p < 4; p++) begin
      tlps_left[p] = 0; nbeats[p] = 0; bad_first[p] = 1'b0;
      src_tlp[p] = 0; src_beat[p] = 0; snk_tlp[p] = 0; snk_beat[p] = 0; rx_cnt[p] = 0;
    end
    exp_total = 0; rx_total = 0; last_acc = -1;
    toggle_rdy = 1'b0; long_chk = 1'b0; gap_chk = 1'b0; sel5 = 1'b0;
    gnt_q.delete();
  endtask

  task automatic plan(input int p, input int ntlp, input int nb, input bit bad);
    tlps_left[p] = ntlp; nbeats[p] = nb; bad_first[p] = bad;
    exp_total += ntlp * nb;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    for (int p = 0; p < 4; p++) in_data[p] = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One cycle per iteration: drive at negedge, decide handshakes 1 ns later.
  task automatic run(input int budget, input int fixed);
    bit done;
    int p, n;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clock);
      for (int q = 0; q < 4; q++) begin
        if (tlps_left[q] > 0) begin
          in_valid[q] = 1'b1;
          in_data[q]  = beat_of(q, src_tlp[q], src_beat[q]);
        end else begin
          in_valid[q] = 1'b0;
          in_data[q]  = '0;
        end
      end
      out_ready = toggle_rdy ? (cyc % 2 == 0) : 1'b1;
      #1;
      check("rdy_onehot", 66'($countones(s_rdy) <= 1), 66'(1));
      if (sel5) check("rdy5_disabled", 66'(s_rdy[3:2]), 66'(0));
      if (s_ov && out_ready) begin
        p = int'(s_port);
        check($sformatf("rx_data_p%0d", p), s_od, beat_of(p, snk_tlp[p], snk_beat[p]));
        if (snk_beat[p] == 0) gnt_q.push_back(p);
        if (long_chk && p == 3) begin
          n = snk_beat[p] + 1;
          if (n <= 16)      check($sformatf("err_low_beat%0d", n), 66'(s_err), 66'(0));
          else if (n >= 18) check($sformatf("err_high_beat%0d", n), 66'(s_err), 66'(1));
        end
        if (snk_beat[p] == nbeats[p] - 1) begin snk_beat[p] = 0; snk_tlp[p]++; end
        else snk_beat[p]++;
        rx_cnt[p]++;
        rx_total++;
      end
      for (int q = 0; q < 4; q++) begin
        if (in_valid[q] && s_rdy[q]) begin
          if (gap_chk && last_acc >= 0) check("accept_gap", 66'(cyc - last_acc), 66'(2));
          last_acc = cyc;
          if (src_beat[q] == nbeats[q] - 1) begin
            src_beat[q] = 0; src_tlp[q]++; tlps_left[q]--;
          end else src_beat[q]++;
        end
      end
      cyc++;
      if (fixed > 0) done = (c + 1 >= fixed);
      else done = (rx_total == exp_total) && (tlps_left[0] + tlps_left[1] + tlps_left[2] + tlps_left[3] == 0);
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL run_timeout: got %0d of %0d beats expected all", rx_total, exp_total);
    end
  endtask

  // ---------------- cycle table for the two-port handoff ----------------
  typedef struct {
    logic [3:0]  valid;
    logic [65:0] d0;
    logic [65:0] d1;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_ov;
    logic [65:0] e_od;
    logic [1:0]  e_port;
    logic [63:0] e_pkt;
  } vec_t;

  vec_t vt [10];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [65:0] p0, p1, p2, q0, q1, q2, zz;
    bit got;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    clear_plan();

    // Reset values, with every port requesting during reset.
    reset_n   = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'hF;
    for (int p = 0; p < 4; p++) in_data[p] = mk(p, 0, 0, 1'b1, 1'b1);
    repeat (2) @(negedge clock);
    #1;
    check("rst_in_ready",  66'(in_ready),  66'(0));
    check("rst_in_ready5", 66'(in_ready5), 66'(0));
    check("rst_out_valid", 66'(out_valid), 66'(0));
    check("rst_out_data",  out_data,       66'(0));
    check("rst_out_port",  66'(out_port),  66'(0));
    check("rst_err",       66'(err),       66'(0));
    check("rst_pkt_count", 66'(pkt_count), 66'(0));
    in_valid = '0;
    for (int p = 0; p < 4; p++) in_data[p] = '0;
    @(negedge clock);
    reset_n = 1'b1;

    // Test 1: ports 0 and 1 each send a 3-beat TLP, out_ready held high.
    p0 = mk(0, 0, 0, 1'b1, 1'b0); p1 = mk(0, 0, 1, 1'b0, 1'b0); p2 = mk(0, 0, 2, 1'b0, 1'b1);
    q0 = mk(1, 0, 0, 1'b1, 1'b0); q1 = mk(1, 0, 1, 1'b0, 1'b0); q2 = mk(1, 0, 2, 1'b0, 1'b1);
    zz = '0;
    vt[0] = '{4'b0011, p0, q0, 1'b1, 4'b0000, 1'b0, zz, 2'd0, 64'h0};
    vt[1] = '{4'b0011, p0, q0, 1'b1, 4'b0001, 1'b0, zz, 2'd0, 64'h0};
    vt[2] = '{4'b0011, p1, q0, 1'b1, 4'b0001, 1'b1, p0, 2'd0, 64'h0};
    vt[3] = '{4'b0011, p2, q0, 1'b1, 4'b0001, 1'b1, p1, 2'd0, 64'h0};
    vt[4] = '{4'b0010, zz, q0, 1'b1, 4'b0000, 1'b1, p2, 2'd0, 64'h1};
    vt[5] = '{4'b0010, zz, q0, 1'b1, 4'b0010, 1'b0, zz, 2'd0, 64'h1};
    vt[6] = '{4'b0010, zz, q1, 1'b1, 4'b0010, 1'b1, q0, 2'd1, 64'h1};
    vt[7] = '{4'b0010, zz, q2, 1'b1, 4'b0010, 1'b1, q1, 2'd1, 64'h1};
    vt[8] = '{4'b0000, zz, zz, 1'b1, 4'b0000, 1'b1, q2, 2'd1, 64'h0000_0000_0001_0001};
    vt[9] = '{4'b0000, zz, zz, 1'b1, 4'b0000, 1'b0, zz, 2'd1, 64'h0000_0000_0001_0001};
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      in_valid   = vt[i].valid;
      in_data[0] = vt[i].d0;
      in_data[1] = vt[i].d1;
      out_ready  = vt[i].ordy;
      #1;
      check($sformatf("t1_in_ready[%0d]", i),  66'(in_ready),  66'(vt[i].e_rdy));
      check($sformatf("t1_out_valid[%0d]", i), 66'(out_valid), 66'(vt[i].e_ov));
      check($sformatf("t1_pkt_count[%0d]", i), 66'(pkt_count), 66'(vt[i].e_pkt));
      if (vt[i].e_ov || i == 0) begin
        check($sformatf("t1_out_data[%0d]", i), out_data,       vt[i].e_od);
        check($sformatf("t1_out_port[%0d]", i), 66'(out_port),  66'(vt[i].e_port));
      end
    end
    check("t1_err", 66'(err), 66'(0));

    // Test 2: 17-beat TLP on port 2 with out_ready toggling.
    do_reset(); clear_plan();
    plan(2, 1, 17, 1'b0);
    toggle_rdy = 1'b1;
    run(200, 0);
    check("t2_rx_cnt",    66'(rx_cnt[2]), 66'(17));
    check("t2_rx_total",  66'(rx_total),  66'(17));
    check("t2_err",       66'(err),       66'(0));
    check("t2_pkt_count", 66'(pkt_count), 66'(64'h0000_0001_0000_0000));

    // Test 3: port 3 sends 18 beats without the last flag, then a closing beat.
    do_reset(); clear_plan();
    plan(3, 1, 19, 1'b0);
    long_chk = 1'b1;
    run(200, 0);
    check("t3_rx_cnt", 66'(rx_cnt[3]), 66'(19));
    check("t3_err",    66'(err),       66'(1));
    check("t3_pkt3",   66'(pkt_count[63:48]), 66'(1));
    repeat (5) @(negedge clock);
    #1;
    check("t3_err_sticky", 66'(err), 66'(1));
    do_reset();
    #1;
    check("t3_err_cleared", 66'(err), 66'(0));

    // Header flag missing on the first beat.
    clear_plan();
    plan(0, 1, 2, 1'b1);
    run(50, 0);
    check("hdr_rx_cnt", 66'(rx_cnt[0]), 66'(2));
    check("hdr_err",    66'(err),       66'(1));
    check("hdr_pkt0",   66'(pkt_count), 66'(64'h1));

    // Test 4: all ports always valid with single-beat TLPs.
    do_reset(); clear_plan();
    for (int p = 0; p < 4; p++) plan(p, 3, 1, 1'b0);
    gap_chk = 1'b1;
    run(100, 0);
    check("t4_gnt_count", 66'(gnt_q.size()), 66'(12));
    foreach (gnt_q[i]) check($sformatf("t4_gnt_order[%0d]", i), 66'(gnt_q[i]), 66'(i % 4));
    check("t4_pkt_count", 66'(pkt_count), 66'(64'h0003_0003_0003_0003));
    check("t4_err",       66'(err),       66'(0));

    // Test 5: ENABLE=8'h30 instance with every port requesting.
    do_reset(); clear_plan();
    sel5 = 1'b1;
    plan(0, 2, 2, 1'b0); plan(1, 2, 2, 1'b0);
    plan(2, 50, 1, 1'b0); plan(3, 50, 1, 1'b0);
    run(30, 30);
    check("t5_left0",     66'(tlps_left[0]), 66'(0));
    check("t5_left1",     66'(tlps_left[1]), 66'(0));
    check("t5_left2",     66'(tlps_left[2]), 66'(50));
    check("t5_rx2",       66'(rx_cnt[2]),    66'(0));
    check("t5_rx3",       66'(rx_cnt[3]),    66'(0));
    check("t5_pkt_count", 66'(s_pkt),        66'(64'h0000_0000_0002_0002));
    sel5 = 1'b0;

    // Test 6: reset in the middle of a port-1 TLP after the pointer has moved.
    do_reset(); clear_plan();
    plan(0, 1, 2, 1'b0);
    run(50, 0);
    @(negedge clock);
    in_valid   = 4'b0010;
    in_data[1] = mk(1, 0, 0, 1'b1, 1'b0);
    out_ready  = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (in_ready[1]) got = 1'b1;
      else @(negedge clock);
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL t6_grant_timeout: got in_ready %b expected bit 1 high", in_ready);
    end
    @(negedge clock);
    in_data[1] = mk(1, 0, 1, 1'b0, 1'b0);
    #1;
    check("t6_mid_ready", 66'(in_ready),  66'(4'b0010));
    check("t6_mid_valid", 66'(out_valid), 66'(1));
    check("t6_mid_port",  66'(out_port),  66'(1));
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 66'(out_valid), 66'(0));
    check("t6_rst_ready", 66'(in_ready),  66'(0));
    check("t6_rst_data",  out_data,       66'(0));
    check("t6_rst_pkt",   66'(pkt_count), 66'(0));
    @(negedge clock);
    reset_n    = 1'b1;
    in_valid   = 4'b0011;
    in_data[0] = mk(0, 1, 0, 1'b1, 1'b0);
    in_data[1] = mk(1, 1, 0, 1'b1, 1'b0);
    #1;
    check("t6_idle_ready", 66'(in_ready), 66'(0));
    @(negedge clock);
    #1;
    check("t6_first_gnt", 66'(in_ready), 66'(4'b0001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
